instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of program_counter: takes its pc_out as pc_in, runs a req/ack handshake to instruction memory, and delivers a registered {valid, pc, instr} bundle to the IF/ID boundary.
- Drives pc_stall_out back into program_counter stall_in, so the PC advances only when a fetch completes.
- Handles variable-latency memory, decode back-pressure, and branch-redirect flush with an outstanding request.

Parameters:
RESET_PC, 32'h00400000, value of if_pc_out after reset.
PC_STEP, 4, increment used for if_pc4_out.

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_in  input  1  synchronous, active-high reset
pc_in  input  32  current PC from program_counter
stall_in  input  1  decode cannot accept; output bundle must hold
flush_in  input  1  redirect; discard all fetched/in-flight instructions
imem_req_out  output  1  memory request
imem_addr_out  output  32  request address
imem_ack_in  input  1  memory response; imem_rdata_in valid this cycle
imem_rdata_in  input  32  instruction word
if_valid_out  output  1  bundle valid
if_pc_out  output  32  PC of bundled instruction
if_pc4_out  output  32  if_pc_out + PC_STEP (combinational, wraps mod 2^32)
if_instr_out  output  32  instruction word
pc_stall_out  output  1  to program_counter stall_in

Behaviour:
- Reset values: state IDLE, if_valid_out 0, if_instr_out 0, if_pc_out RESET_PC, hold buffer empty, imem_req_out 0, pc_stall_out 1.
- Reset mid-request drops imem_req_out on the next cycle. Memory must abandon the request. Any later ack is ignored.
- States: IDLE, REQ, HOLD, DROP. IDLE lasts one cycle after reset, then goes to REQ unconditionally.
- Handshake: imem_req_out = (state==REQ || state==DROP).
  - The address is held stable until ack.
  - imem_addr_out = pc_in in REQ, addr_q in DROP. addr_q captures pc_in every REQ cycle.
  - Ack is sampled only while req is high. Ack in IDLE or HOLD is ignored.
- Accept: acc = state==REQ & imem_ack_in & ~flush_in.
  - slot_free = ~if_valid_out | ~stall_in.
  - acc & slot_free: bundle <= {1, pc_in, imem_rdata_in}; stay in REQ.
  - acc & ~slot_free: hold buffer <= {pc_in, imem_rdata_in}; go to HOLD.
- Throughput and latency:
  - Zero-wait memory sustains 1 instruction per cycle.
  - Ack in cycle t makes the bundle visible in cycle t+1.
- pc_stall_out = 0 when acc, or when flush_in (so the PC loads the redirect target). Otherwise 1, including throughout IDLE, HOLD, and DROP.
- Bundle when no accept: if ~stall_in, if_valid_out <= 0. If stall_in, all bundle fields hold.
- HOLD: when ~stall_in, bundle <= hold buffer (valid 1), then go to REQ. No request is issued in HOLD.
- Flush (priority over everything except reset): next cycle if_valid_out = 0 and the hold buffer is cleared.
  - REQ without ack goes to DROP. Memory completes the old addr_q request; the data is discarded.
  - REQ with ack in the same cycle: data is discarded; stay in REQ.
  - HOLD or IDLE goes to REQ.
  - DROP stays in DROP.
- DROP: on ack, discard data and go to REQ (fetches the new pc_in).
- flush_in and stall_in together: flush wins; the bundle is invalidated.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output perf_fetch_cnt_out[31:0], counting cycles with acc.
  - Adds output perf_stall_cnt_out[31:0], counting cycles with pc_stall_out=1 outside IDLE.
  - Both clear on rst_in and wrap at 2^32.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset, then zero-wait ack with rdata = pc: imem_req_out rises in cycle 2 with addr 0x00400000. Bundles 0x00400000, 0x00400004, 0x00400008 appear on consecutive cycles with if_pc4_out = pc+4.
- Ack delayed 3 cycles: req and addr are held stable, pc_stall_out stays 1 for 3 cycles, then the bundle appears the cycle after ack.
- stall_in held 4 cycles with valid bundle and an ack arriving: the bundle holds and the state goes to HOLD with no req. After release, the buffered instruction emits, then fetching resumes at the next PC.
- flush_in in REQ without ack, target 0x00400100, ack 2 cycles later: the state goes to DROP and addr stays at the old PC. The old data is discarded and the next request uses 0x00400100. No stale valid bundle appears.
- Reset asserted with a request outstanding: one cycle later req=0, valid=0, if_pc_out=0x00400000. A late ack produces no bundle.
- With FETCH_PERF_CNT_EN defined: 5 fetches plus one 3-cycle wait give perf_fetch_cnt_out=5 and perf_stall_cnt_out=3.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Fetch stage between program_counter and the IF/ID boundary.
//                Runs a req/ack handshake to instruction memory, registers a
//                {valid, pc, instr} bundle, holds one overflow instruction
//                when decode stalls, and discards in-flight data on a flush.
//                Optional performance counters are enabled by defining the
//                macro FETCH_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] pc_in,
    input  logic        stall_in,
    input  logic        flush_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_rdata_in,
    output logic        if_valid_out,
    output logic [31:0] if_pc_out,
    output logic [31:0] if_pc4_out,
    output logic [31:0] if_instr_out,
    output logic        pc_stall_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt_out,
    output logic [31:0] perf_stall_cnt_out
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    logic        r_hold_valid;
    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_instr;

    // Address of the request in flight; replayed while draining a flushed fetch.
    logic [31:0] r_addr_q;

    logic        w_acc;
    logic        w_slot_free;
    logic        w_hold_release;

    // Handshake, accept and back-pressure decode.
    always_comb begin
        w_acc          = (r_state == ST_REQ) && imem_ack_in && !flush_in;
        w_slot_free    = !r_valid || !stall_in;
        w_hold_release = (r_state == ST_HOLD) && !stall_in && !flush_in;
        imem_req_out   = (r_state == ST_REQ) || (r_state == ST_DROP);
        imem_addr_out  = (r_state == ST_DROP) ? r_addr_q : pc_in;
        // The PC advances on an accepted fetch, and on a flush so it can
        // load the redirect target.
        pc_stall_out   = !(w_acc || flush_in);
        if_valid_out   = r_valid;
        if_pc_out      = r_pc;
        if_pc4_out     = r_pc + PC_STEP;
        if_instr_out   = r_instr;
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush takes priority over every other condition.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (flush_in) begin
                    // Without ack the old request is still owed by memory.
                    w_state_nxt = imem_ack_in ? ST_REQ : ST_DROP;
                end else if (w_acc && !w_slot_free) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (flush_in || !stall_in) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DROP: begin
                // The abandoned request completes here; its data is thrown
                // away and the next request uses the (redirected) pc_in.
                if (imem_ack_in) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output bundle register toward the IF/ID boundary.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid <= 1'b0;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
        end else if (flush_in) begin
            r_valid <= 1'b0;
        end else if (w_acc && w_slot_free) begin
            r_valid <= 1'b1;
            r_pc    <= pc_in;
            r_instr <= imem_rdata_in;
        end else if (w_hold_release) begin
            r_valid <= 1'b1;
            r_pc    <= r_hold_pc;
            r_instr <= r_hold_instr;
        end else if (!stall_in) begin
            r_valid <= 1'b0;
        end
    end

    // Single-entry hold buffer for an instruction accepted while decode stalls.
    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            r_hold_valid <= 1'b0;
            r_hold_pc    <= 32'd0;
            r_hold_instr <= 32'd0;
        end else if (w_acc && !w_slot_free) begin
            r_hold_valid <= 1'b1;
            r_hold_pc    <= pc_in;
            r_hold_instr <= imem_rdata_in;
        end else if (w_hold_release) begin
            r_hold_valid <= 1'b0;
        end
    end

    // Track the address presented during every REQ cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_addr_q <= RESET_PC;
        end else if (r_state == ST_REQ) begin
            r_addr_q <= pc_in;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_stall_cnt;

    // Count accepted fetches and stalled non-IDLE cycles; both wrap.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_perf_fetch_cnt <= 32'd0;
            r_perf_stall_cnt <= 32'd0;
        end else begin
            if (w_acc) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if (pc_stall_out && (r_state != ST_IDLE)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt_out = r_perf_fetch_cnt;
    assign perf_stall_cnt_out = r_perf_stall_cnt;
`endif

endmodule
`default_nettype wire
